// File: rtl/tf_slowbus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// tf_slowbus_ctrl_pkg
//   Shared definitions for the TF53x 68030->68000 slow-bus controller:
//   FSM state encodings (3-bit, legacy-compatible), 68030 SIZ codes, the
//   inactive level of the active-low 68000 strobes, and the data-strobe lane
//   decode.
// -----------------------------------------------------------------------------
package tf_slowbus_ctrl_pkg;

  // FSM state encodings
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_QUAL  = 3'd1;
  localparam logic [2:0] ST_ASRT  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_VPA   = 3'd4;
  localparam logic [2:0] ST_TERM  = 3'd5;
  localparam logic [2:0] ST_RECOV = 3'd6;
  localparam logic [2:0] ST_BERR  = 3'd7;  // timeout termination, waits for F7

  // 68030 transfer size codes
  localparam logic [1:0] SIZ_LONG  = 2'b00;
  localparam logic [1:0] SIZ_BYTE  = 2'b01;
  localparam logic [1:0] SIZ_WORD  = 2'b10;
  localparam logic [1:0] SIZ_LINE3 = 2'b11;

  // Released level of every active-low 68000 strobe
  localparam logic STROBE_OFF = 1'b1;

  // Returns {uds_n, lds_n}. The upper lane is used for even addresses; the
  // lower lane for odd addresses or any transfer wider than a byte.
  function automatic logic [1:0] ds_lanes(input logic a0, input logic [1:0] siz);
    return {a0, ~(a0 | (siz != SIZ_BYTE))};
  endfunction

endpackage

// File: rtl/tf_clk7m_edge.sv
// -----------------------------------------------------------------------------
// tf_clk7m_edge
//   Brings the Amiga CLK7M into the CPU clock domain as data: a 2-flop
//   synchroniser followed by one history flop, producing single-cycle pulses
//   on each sampled rising (rise_o) and falling (fall_o) edge.
// Ports
//   clk      in   sampling clock (CLKCPU)
//   rst_n    in   asynchronous active-low reset
//   clk7m_i  in   raw CLK7M
//   rise_o   out  one-cycle pulse, sampled CLK7M rising edge
//   fall_o   out  one-cycle pulse, sampled CLK7M falling edge
// -----------------------------------------------------------------------------
module tf_clk7m_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic clk7m_i,
  output logic rise_o,
  output logic fall_o
);

  // [0],[1] synchroniser; [2] previous synchronised value for edge detect
  logic [2:0] sync_q;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[1:0], clk7m_i};
  end

  assign rise_o =  sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] &  sync_q[2];

endmodule

// File: rtl/tf_slowbus_ctrl.sv
// -----------------------------------------------------------------------------
// tf_slowbus_ctrl
//   68030 -> 68000 slow-bus cycle controller for TF53x boards. Everything runs
//   on CLKCPU; CLK7M is sampled as data. Qualifies external cycles, drives the
//   68000 strobes, runs DTACK or VPA/E-clock cycles and returns DSACK1.
//   Optional feature: define TF_BUS_TIMEOUT_EN to enable the bus-error
//   timeout (BERR after TIMEOUT CLK7M rising edges without termination).
// Parameters
//   SYNC_DEPTH  CLK7M rises INTCYCLE must stay high before a slow cycle (1..15)
//   E_DIV       CLK7M periods per E period (>=4)
//   E_HIGH      CLK7M periods E is high per period (1..E_DIV-2)
//   TIMEOUT     CLK7M rises in WAIT/VPA before BERR (1..255)
// Ports
//   CLKCPU, RESET_N                 clock, async active-low reset
//   CLK7M                           Amiga 7 MHz clock (data)
//   AS20, DS20, RW20, SIZ, A0       68030 cycle signals
//   INTCYCLE                        1 = no internal resource claims the cycle
//   BGACK, DTACK, VPA               68000-side inputs, active low
//   AS, UDS, LDS, RW, VMA, E        68000-side outputs
//   DSACK1, BERR                    68030 termination, active low
//   SLOWCYCLE                       0 while a slow cycle is qualified/running
// -----------------------------------------------------------------------------
module tf_slowbus_ctrl
  import tf_slowbus_ctrl_pkg::*;
#(
  parameter int SYNC_DEPTH = 4,
  parameter int E_DIV      = 10,
  parameter int E_HIGH     = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic       CLKCPU,
  input  logic       RESET_N,
  input  logic       CLK7M,
  input  logic       AS20,
  input  logic       DS20,
  input  logic       RW20,
  input  logic [1:0] SIZ,
  input  logic       A0,
  input  logic       INTCYCLE,
  input  logic       BGACK,
  input  logic       DTACK,
  input  logic       VPA,
  output logic       AS,
  output logic       UDS,
  output logic       LDS,
  output logic       RW,
  output logic       VMA,
  output logic       E,
  output logic       DSACK1,
  output logic       BERR,
  output logic       SLOWCYCLE
);

  localparam int EW = (E_DIV > 2) ? $clog2(E_DIV) : 1;
  localparam logic [EW-1:0] E_LAST = EW'(E_DIV - 1);
  localparam logic [EW-1:0] E_RISE = EW'(E_DIV - E_HIGH);
  localparam logic [EW-1:0] E_VMA  = EW'(E_DIV - E_HIGH - 1);
  localparam logic [3:0]    Q_DONE = 4'(SYNC_DEPTH);

  logic r7, f7;

  tf_clk7m_edge u_edge (
    .clk     (CLKCPU),
    .rst_n   (RESET_N),
    .clk7m_i (CLK7M),
    .rise_o  (r7),
    .fall_o  (f7)
  );

  logic [2:0]    state_q, state_d;
  logic [3:0]    qcnt_q,  qcnt_d;
  logic [EW-1:0] e_cnt_q, e_cnt_d;
  logic as_q, as_d, uds_q, uds_d, lds_q, lds_d, rw_q, rw_d;
  logic vma_q, vma_d, dsack_q, dsack_d, berr_q, berr_d, slow_q, slow_d;
`ifdef TF_BUS_TIMEOUT_EN
  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  logic [7:0] to_cnt_q, to_cnt_d;
`endif

  // Free-running E divider; only CLK7M rises advance it.
  always_comb begin
    e_cnt_d = e_cnt_q;
    if (r7) e_cnt_d = (e_cnt_q == E_LAST) ? '0 : e_cnt_q + 1'b1;
  end

  // NOTE: every signal assigned in this block gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    as_d    = as_q;
    uds_d   = uds_q;
    lds_d   = lds_q;
    rw_d    = rw_q;
    vma_d   = vma_q;
    dsack_d = dsack_q;
    berr_d  = berr_q;
    slow_d  = slow_q;

    case (state_q)
      ST_IDLE: if (!AS20 && BGACK) begin
        state_d = ST_QUAL;
        qcnt_d  = '0;
      end
      ST_QUAL: if (r7) begin
        if (!INTCYCLE) begin
          state_d = ST_RECOV;                 // internal resource took it
        end else begin
          qcnt_d = qcnt_q + 1'b1;
          if (qcnt_d == Q_DONE) begin
            state_d = ST_ASRT;
            slow_d  = 1'b0;
          end
        end
      end
      ST_ASRT: if (f7) begin
        if (as_q) begin                       // first F7: address phase
          as_d = 1'b0;
          rw_d = RW20;
          if (RW20) begin
            {uds_d, lds_d} = ds_lanes(A0, SIZ);
            state_d = ST_WAIT;
          end
        end else if (!DS20) begin             // write: data strobes one F7 later
          {uds_d, lds_d} = ds_lanes(A0, SIZ);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (f7 && !DTACK) begin
          state_d = ST_TERM;
          dsack_d = 1'b0;
        end else if (r7 && !VPA && DTACK) begin
          state_d = ST_VPA;
        end
      end
      ST_VPA: if (r7) begin
        if (e_cnt_d == E_VMA) begin
          vma_d = 1'b0;
        end else if (e_cnt_d == '0 && !vma_q) begin
          // Terminate on the E falling edge, only after a full VMA window
          state_d = ST_TERM;
          dsack_d = 1'b0;
          vma_d   = 1'b1;
        end
      end
      ST_TERM, ST_BERR: if (f7) begin
        as_d    = STROBE_OFF;
        uds_d   = STROBE_OFF;
        lds_d   = STROBE_OFF;
        vma_d   = 1'b1;
        state_d = ST_RECOV;
      end
      ST_RECOV: ;                             // held until AS20 negates
      default: state_d = ST_IDLE;
    endcase

`ifdef TF_BUS_TIMEOUT_EN
    to_cnt_d = to_cnt_q;
    if (state_q == ST_ASRT) begin
      to_cnt_d = '0;
    end else if (r7 && (state_q == ST_WAIT || state_q == ST_VPA)) begin
      to_cnt_d = to_cnt_q + 8'd1;
      // A real termination on the same edge wins, keeping BERR/DSACK1 exclusive
      if (to_cnt_d == TO_LIMIT && state_d != ST_TERM) begin
        berr_d  = 1'b0;
        state_d = ST_BERR;
      end
    end
`endif

    // AS20 negation ends the cycle from any state: abort, or RECOV exit.
    if (AS20) begin
      state_d = ST_IDLE;
      as_d    = STROBE_OFF;
      uds_d   = STROBE_OFF;
      lds_d   = STROBE_OFF;
      rw_d    = 1'b1;
      vma_d   = 1'b1;
      dsack_d = 1'b1;
      berr_d  = 1'b1;
      slow_d  = 1'b1;
    end
  end

  always_ff @(posedge CLKCPU or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      qcnt_q  <= '0;
      e_cnt_q <= '0;
      as_q    <= STROBE_OFF;
      uds_q   <= STROBE_OFF;
      lds_q   <= STROBE_OFF;
      rw_q    <= 1'b1;
      vma_q   <= 1'b1;
      dsack_q <= 1'b1;
      berr_q  <= 1'b1;
      slow_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      e_cnt_q <= e_cnt_d;
      as_q    <= as_d;
      uds_q   <= uds_d;
      lds_q   <= lds_d;
      rw_q    <= rw_d;
      vma_q   <= vma_d;
      dsack_q <= dsack_d;
      berr_q  <= berr_d;
      slow_q  <= slow_d;
    end
  end

`ifdef TF_BUS_TIMEOUT_EN
  always_ff @(posedge CLKCPU or negedge RESET_N) begin
    if (!RESET_N) to_cnt_q <= '0;
    else          to_cnt_q <= to_cnt_d;
  end
`endif

  assign AS        = as_q;
  assign UDS       = uds_q;
  assign LDS       = lds_q;
  assign RW        = rw_q;
  assign VMA       = vma_q;
  assign E         = (e_cnt_q >= E_RISE);
  assign DSACK1    = dsack_q;
  assign BERR      = berr_q;
  assign SLOWCYCLE = slow_q;

endmodule

// File: tb/tb_tf_slowbus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tf_slowbus_ctrl
//   Directed bench for tf_slowbus_ctrl. u_dut uses SYNC_DEPTH=4, u_dut1 uses
//   SYNC_DEPTH=1; both share all inputs. CLK7M is generated in lockstep with
//   CLKCPU (period 8 CPU clocks) so the 3-flop sampling latency is fixed: a
//   CLK7M edge takes effect on the third CLKCPU rising edge after it.
// -----------------------------------------------------------------------------
module tb_tf_slowbus_ctrl;

  logic clk = 1'b0, rst_n = 1'b0, clk7m = 1'b0;
  logic as20 = 1'b1, ds20 = 1'b1, rw20 = 1'b1, a0 = 1'b0;
  logic intcycle = 1'b1, bgack = 1'b1, dtack = 1'b1, vpa = 1'b1;
  logic [1:0] siz = 2'b01;

  logic as_o, uds_o, lds_o, rw_o, vma_o, e_o, dsack_o, berr_o, slow_o;
  logic as1, uds1, lds1, rw1, vma1, e1, dsack1, berr1, slow1;

  int vecs = 0;
  int errs = 0;
  logic seen, ok;

`ifdef TF_BUS_TIMEOUT_EN
  localparam logic EXP_BERR    = 1'b0;
  localparam logic EXP_AS_LATE = 1'b1;
`else
  localparam logic EXP_BERR    = 1'b1;
  localparam logic EXP_AS_LATE = 1'b0;
`endif

  tf_slowbus_ctrl #(.SYNC_DEPTH(4), .E_DIV(10), .E_HIGH(4), .TIMEOUT(16)) u_dut (
    .CLKCPU(clk), .RESET_N(rst_n), .CLK7M(clk7m), .AS20(as20), .DS20(ds20),
    .RW20(rw20), .SIZ(siz), .A0(a0), .INTCYCLE(intcycle), .BGACK(bgack),
    .DTACK(dtack), .VPA(vpa), .AS(as_o), .UDS(uds_o), .LDS(lds_o), .RW(rw_o),
    .VMA(vma_o), .E(e_o), .DSACK1(dsack_o), .BERR(berr_o), .SLOWCYCLE(slow_o)
  );

  tf_slowbus_ctrl #(.SYNC_DEPTH(1), .E_DIV(10), .E_HIGH(4), .TIMEOUT(16)) u_dut1 (
    .CLKCPU(clk), .RESET_N(rst_n), .CLK7M(clk7m), .AS20(as20), .DS20(ds20),
    .RW20(rw20), .SIZ(siz), .A0(a0), .INTCYCLE(intcycle), .BGACK(bgack),
    .DTACK(dtack), .VPA(vpa), .AS(as1), .UDS(uds1), .LDS(lds1), .RW(rw1),
    .VMA(vma1), .E(e1), .DSACK1(dsack1), .BERR(berr1), .SLOWCYCLE(slow1)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (4) @(negedge clk);
      clk7m = ~clk7m;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000");
    $fatal(1);
  end

  task automatic check(input string tag, input logic obs, input logic exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Return just after the CPU edge that applies the next CLK7M rise / fall
  task automatic wait7r();
    @(posedge clk7m); repeat (3) tick();
  endtask

  task automatic wait7f();
    @(negedge clk7m); repeat (3) tick();
  endtask

  // All u_dut outputs at their released/reset levels
  task automatic check_rel(input string tag);
    check({tag, "_as"},    as_o,    1'b1);
    check({tag, "_uds"},   uds_o,   1'b1);
    check({tag, "_lds"},   lds_o,   1'b1);
    check({tag, "_rw"},    rw_o,    1'b1);
    check({tag, "_vma"},   vma_o,   1'b1);
    check({tag, "_dsack"}, dsack_o, 1'b1);
    check({tag, "_berr"},  berr_o,  1'b1);
    check({tag, "_slow"},  slow_o,  1'b1);
  endtask

  initial begin
    #22 rst_n = 1'b1;
    tick();
    check_rel("reset");
    check("reset_e", e_o, 1'b0);

    // ---- read byte, A0=1, DTACK terminated ----
    wait7r();
    rw20 = 1'b1; siz = 2'b01; a0 = 1'b1; ds20 = 1'b0; as20 = 1'b0;
    repeat (3) wait7r();
    check("rd_slow_before_4th", slow_o, 1'b1);
    wait7r();
    check("rd_slow_after_4th", slow_o, 1'b0);
    check("rd_as_before_f7", as_o, 1'b1);
    wait7f();
    check("rd_as", as_o, 1'b0);
    check("rd_uds", uds_o, 1'b1);
    check("rd_lds", lds_o, 1'b0);
    check("rd_rw", rw_o, 1'b1);
    wait7r(); wait7r();
    dtack = 1'b0;
    @(negedge clk7m); repeat (2) tick();
    check("rd_dsack_pre", dsack_o, 1'b1);
    tick();
    check("rd_dsack", dsack_o, 1'b0);
    check("rd_berr", berr_o, 1'b1);
    wait7f();
    check("rd_rel_as", as_o, 1'b1);
    check("rd_rel_lds", lds_o, 1'b1);
    check("rd_dsack_held", dsack_o, 1'b0);
    dtack = 1'b1; as20 = 1'b1;
    tick();
    check_rel("rd_end");

    // ---- INTCYCLE drops before the 2nd rise: internal cycle ----
    wait7r();
    as20 = 1'b0; rw20 = 1'b1;
    wait7r();
    intcycle = 1'b0;
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (as_o !== 1'b1 || uds_o !== 1'b1 || lds_o !== 1'b1 ||
          dsack_o !== 1'b1 || slow_o !== 1'b1) seen = 1'b1;
    end
    check("int_no_activity", seen, 1'b0);
    as20 = 1'b1; intcycle = 1'b1;
    tick();
    check_rel("int_end");

    // ---- VPA / E-clock cycle ----
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin tick(); if (e_o === 1'b1) ok = 1'b1; end
    check("vpa_e_rises", ok, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin tick(); if (e_o === 1'b0) ok = 1'b1; end
    check("vpa_e_falls", ok, 1'b1);
    // E count is now 0
    vpa = 1'b0; dtack = 1'b1; rw20 = 1'b1; siz = 2'b10; a0 = 1'b0; as20 = 1'b0;
    repeat (4) wait7r();                       // counts 1..4
    wait7f();
    check("vpa_as", as_o, 1'b0);
    wait7r();                                  // count 5, WAIT -> VPA
    check("vpa_vma_late5", vma_o, 1'b1);
    repeat (4) wait7r();                       // counts 6..9
    check("vpa_e_high", e_o, 1'b1);
    wait7r();                                  // count 0
    check("vpa_no_early_term", dsack_o, 1'b1);
    check("vpa_e_low", e_o, 1'b0);
    repeat (4) wait7r();                       // counts 1..4
    check("vpa_vma_before5", vma_o, 1'b1);
    wait7r();                                  // count 5
    check("vpa_vma_at5", vma_o, 1'b0);
    check("vpa_e_at5", e_o, 1'b0);
    repeat (4) wait7r();                       // counts 6..9
    check("vpa_dsack_at9", dsack_o, 1'b1);
    check("vpa_vma_at9", vma_o, 1'b0);
    @(posedge clk7m); repeat (2) tick();
    check("vpa_dsack_pre_fall", dsack_o, 1'b1);
    check("vpa_e_pre_fall", e_o, 1'b1);
    tick();
    check("vpa_dsack_at_fall", dsack_o, 1'b0);
    check("vpa_e_at_fall", e_o, 1'b0);
    check("vpa_vma_term", vma_o, 1'b1);
    wait7f();
    check("vpa_release", as_o, 1'b1);
    vpa = 1'b1; as20 = 1'b1;
    tick();
    check_rel("vpa_end");

    // ---- no termination: timeout (or indefinite wait) ----
    wait7r();
    rw20 = 1'b1; siz = 2'b01; a0 = 1'b1; as20 = 1'b0;
    repeat (4) wait7r();
    wait7f();
    check("to_as", as_o, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin wait7r(); if (dsack_o !== 1'b1) seen = 1'b1; end
    check("to_berr_pre", berr_o, 1'b1);
    wait7r();
    check("to_berr", berr_o, EXP_BERR);
    wait7f();
    check("to_as_after", as_o, EXP_AS_LATE);
    if (dsack_o !== 1'b1) seen = 1'b1;
    check("to_dsack_never", seen, 1'b0);
    as20 = 1'b1;
    tick();
    check_rel("to_end");

    // ---- SYNC_DEPTH=1 word write, aborted mid-WAIT (u_dut1) ----
    wait7r();
    rw20 = 1'b0; siz = 2'b10; a0 = 1'b0; ds20 = 1'b0; as20 = 1'b0;
    wait7r();
    check("wr_slow", slow1, 1'b0);
    check("wr_as_pre", as1, 1'b1);
    wait7f();
    check("wr_as", as1, 1'b0);
    check("wr_rw", rw1, 1'b0);
    check("wr_uds_lag", uds1, 1'b1);
    check("wr_lds_lag", lds1, 1'b1);
    wait7f();
    check("wr_uds", uds1, 1'b0);
    check("wr_lds", lds1, 1'b0);
    wait7r();
    as20 = 1'b1;
    tick();
    check("ab_as", as1, 1'b1);
    check("ab_uds", uds1, 1'b1);
    check("ab_lds", lds1, 1'b1);
    check("ab_rw", rw1, 1'b1);
    check("ab_slow", slow1, 1'b1);
    check("ab_dsack", dsack1, 1'b1);
    as20 = 1'b0;
    wait7r();
    check("ab_requalify", slow1, 1'b0);
    as20 = 1'b1; rw20 = 1'b1;
    tick();

    // ---- async reset mid-WAIT ----
    wait7r();
    as20 = 1'b0;
    repeat (4) wait7r();
    wait7f();
    check("rst_as_pre", as_o, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_rel("rst_mid");
    check("rst_mid_e", e_o, 1'b0);
    check("rst_mid_as1", as1, 1'b1);
    as20 = 1'b1;
    @(negedge clk7m); repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check_rel("rst_after");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
